// File: rtl/icache_pkg.sv
// Shared cache definitions: data width, geometry defaults, tag-width derivation
// and the miss-handling FSM state type.
package icache_pkg;

    localparam int DATA_WIDTH         = 32;
    localparam int DEFAULT_INDEX_BITS = 7;
    localparam int DEFAULT_ADDR_BITS  = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_RESP = 2'd2
    } icache_state_t;

    // Byte offset takes two bits, the index takes indexBits, the rest is tag.
    function automatic int tagBits(input int addrBits, input int indexBits);
        return addrBits - 2 - indexBits;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data line store: combinational read port, one synchronous write
// port, and a synchronous active-low clear of every valid bit.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int TAG_BITS   = tagBits(DEFAULT_ADDR_BITS, DEFAULT_INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_waddr,
    input  logic [TAG_BITS-1:0]   i_wtag,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [INDEX_BITS-1:0] i_raddr,
    output logic                  o_rvalid,
    output logic [TAG_BITS-1:0]   o_rtag,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= 1'b1;
        end
    end

    // Tag and data need no reset; a line is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (rst && i_we) begin
            r_tag[i_waddr]  <= i_wtag;
            r_data[i_waddr] <= i_wdata;
        end
    end

    assign o_rvalid = r_valid[i_raddr];
    assign o_rtag   = r_tag[i_raddr];
    assign o_rdata  = r_data[i_raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped, word-granular instruction cache: one-cycle hits, single
// outstanding miss to the memory unit, honours global pause and rollback.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic                  in_fetcher_ena,
    input  logic [31:0]           in_fetcher_addr,
    output logic                  out_fetcher_ok,
    output logic [DATA_WIDTH-1:0] out_fetcher_inst,
    output logic                  out_mem_ena,
    output logic [31:0]           out_mem_addr,
    input  logic                  in_mem_ok,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    localparam int TAG_BITS = tagBits(ADDR_BITS, INDEX_BITS);

    icache_state_t         r_state;
    logic                  r_ok;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_memEna;
    logic [31:0]           r_memAddr;

    icache_state_t         w_stateNext;
    logic                  w_okNext;
    logic [DATA_WIDTH-1:0] w_instNext;
    logic                  w_memEnaNext;
    logic [31:0]           w_memAddrNext;

    logic [INDEX_BITS-1:0] w_reqIndex;
    logic [TAG_BITS-1:0]   w_reqTag;
    logic                  w_reqIo;
    logic [INDEX_BITS-1:0] w_fillIndex;
    logic [TAG_BITS-1:0]   w_fillTag;
    logic                  w_fillIo;
    logic                  w_rdValid;
    logic [TAG_BITS-1:0]   w_rdTag;
    logic [DATA_WIDTH-1:0] w_rdData;
    logic                  w_hit;
    logic                  w_we;
    logic                  w_unused;

    assign w_reqIndex  = in_fetcher_addr[INDEX_BITS+1:2];
    assign w_reqTag    = in_fetcher_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign w_reqIo     = (in_fetcher_addr[17:16] == 2'b11);
    assign w_fillIndex = r_memAddr[INDEX_BITS+1:2];
    assign w_fillTag   = r_memAddr[ADDR_BITS-1:INDEX_BITS+2];
    assign w_fillIo    = (r_memAddr[17:16] == 2'b11);
    assign w_unused    = ^{in_fetcher_addr[1:0], in_fetcher_addr[31:ADDR_BITS]};

    assign w_hit = w_rdValid && (w_rdTag == w_reqTag) && !w_reqIo;

    // A returning word is filled even under rollback: it is correct for its address.
    assign w_we = ena && (r_state == ST_MISS) && in_mem_ok && !w_fillIo;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_fillIndex),
        .i_wtag   (w_fillTag),
        .i_wdata  (in_mem_data),
        .i_raddr  (w_reqIndex),
        .o_rvalid (w_rdValid),
        .o_rtag   (w_rdTag),
        .o_rdata  (w_rdData)
    );

    always_comb begin
        w_stateNext   = r_state;
        w_okNext      = r_ok;
        w_instNext    = r_inst;
        w_memEnaNext  = r_memEna;
        w_memAddrNext = r_memAddr;

        case (r_state)
            ST_IDLE: begin
                w_okNext = 1'b0;
                if (in_fetcher_ena) begin
                    if (w_hit) begin
                        w_instNext  = w_rdData;
                        w_okNext    = 1'b1;
                        w_stateNext = ST_RESP;
                    end else begin
                        w_memAddrNext = {in_fetcher_addr[31:2], 2'b00};
                        w_memEnaNext  = 1'b1;
                        w_stateNext   = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (in_mem_ok) begin
                    w_instNext   = in_mem_data;
                    w_okNext     = 1'b1;
                    w_memEnaNext = 1'b0;
                    w_stateNext  = ST_RESP;
                end
            end
            ST_RESP: begin
                w_okNext    = 1'b0;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        // Rollback discards whatever the FSM decided this cycle.
        if (in_rollback) begin
            w_stateNext   = ST_IDLE;
            w_okNext      = 1'b0;
            w_memEnaNext  = 1'b0;
            w_instNext    = r_inst;
            w_memAddrNext = r_memAddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ok      <= 1'b0;
            r_inst    <= '0;
            r_memEna  <= 1'b0;
            r_memAddr <= '0;
        end else if (ena) begin
            r_state   <= w_stateNext;
            r_ok      <= w_okNext;
            r_inst    <= w_instNext;
            r_memEna  <= w_memEnaNext;
            r_memAddr <= w_memAddrNext;
        end
    end

    assign out_fetcher_ok   = r_ok;
    assign out_fetcher_inst = r_inst;
    assign out_mem_ena      = r_memEna;
    assign out_mem_addr     = r_memAddr;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized
// fetch/rollback/pause traffic checked against a line-level cache model.
module tb_icache;

    localparam int IB    = 7;
    localparam int AB    = 18;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        in_rollback = 1'b0;
    logic        in_fetcher_ena = 1'b0;
    logic [31:0] in_fetcher_addr = '0;
    logic        out_fetcher_ok;
    logic [31:0] out_fetcher_inst;
    logic        out_mem_ena;
    logic [31:0] out_mem_addr;
    logic        in_mem_ok = 1'b0;
    logic [31:0] in_mem_data = '0;

    int checkCount = 0;
    int errorCount = 0;

    bit          mValid [LINES];
    int          mTag   [LINES];
    logic [31:0] mData  [LINES];

    icache #(
        .INDEX_BITS (IB),
        .ADDR_BITS  (AB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .in_rollback      (in_rollback),
        .in_fetcher_ena   (in_fetcher_ena),
        .in_fetcher_addr  (in_fetcher_addr),
        .out_fetcher_ok   (out_fetcher_ok),
        .out_fetcher_inst (out_fetcher_inst),
        .out_mem_ena      (out_mem_ena),
        .out_mem_addr     (out_mem_addr),
        .in_mem_ok        (in_mem_ok),
        .in_mem_data      (in_mem_data)
    );

    always #5 clk = ~clk;

    function automatic int idxOf(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic int tagOf(input logic [31:0] a);
        return int'(a[17:9]);
    endfunction

    function automatic bit isIo(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        return !isIo(a) && mValid[idxOf(a)] && (mTag[idxOf(a)] == tagOf(a));
    endfunction

    task automatic modelFill(input logic [31:0] a, input logic [31:0] d);
        if (!isIo(a)) begin
            mValid[idxOf(a)] = 1'b1;
            mTag[idxOf(a)]   = tagOf(a);
            mData[idxOf(a)]  = d;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b0;
        in_rollback = 1'b0;
        in_fetcher_ena = 1'b0;
        in_mem_ok = 1'b0;
        ena = 1'b0;
        step();
        ena = 1'b1;
        step();
        checkOutput("rstOk",      {31'd0, out_fetcher_ok}, 32'd0);
        checkOutput("rstInst",    out_fetcher_inst, 32'd0);
        checkOutput("rstMemEna",  {31'd0, out_mem_ena}, 32'd0);
        checkOutput("rstMemAddr", out_mem_addr, 32'd0);
        for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
        rst = 1'b1;
    endtask

    // One fetch: hit or miss as predicted by the model, optional pause while
    // in_mem_ok is pending and optional pause while the answer is shown.
    task automatic applyStimulus(input logic [31:0] addr, input int lat, input int pause,
                                 input logic [31:0] data, input int respPause);
        bit hit;
        hit = modelHit(addr);
        in_fetcher_ena = 1'b1;
        in_fetcher_addr = addr;
        step();
        if (hit) begin
            checkOutput("hitOk",    {31'd0, out_fetcher_ok}, 32'd1);
            checkOutput("hitInst",  out_fetcher_inst, mData[idxOf(addr)]);
            checkOutput("hitNoMem", {31'd0, out_mem_ena}, 32'd0);
        end else begin
            in_fetcher_ena = 1'b0;
            checkOutput("missMemEna", {31'd0, out_mem_ena}, 32'd1);
            checkOutput("missAddr",   out_mem_addr, {addr[31:2], 2'b00});
            checkOutput("missOk",     {31'd0, out_fetcher_ok}, 32'd0);
            for (int k = 0; k < lat; k++) begin
                step();
                checkOutput("waitMemEna", {31'd0, out_mem_ena}, 32'd1);
                checkOutput("waitOk",     {31'd0, out_fetcher_ok}, 32'd0);
            end
            in_mem_data = data;
            in_mem_ok = 1'b1;
            if (pause > 0) begin
                ena = 1'b0;
                for (int k = 0; k < pause; k++) begin
                    step();
                    checkOutput("pauseMemEna", {31'd0, out_mem_ena}, 32'd1);
                    checkOutput("pauseOk",     {31'd0, out_fetcher_ok}, 32'd0);
                end
                ena = 1'b1;
            end
            step();
            in_mem_ok = 1'b0;
            checkOutput("fillOk",     {31'd0, out_fetcher_ok}, 32'd1);
            checkOutput("fillInst",   out_fetcher_inst, data);
            checkOutput("fillMemEna", {31'd0, out_mem_ena}, 32'd0);
            modelFill(addr, data);
            in_fetcher_ena = 1'b1;
        end
        if (respPause > 0) begin
            ena = 1'b0;
            for (int k = 0; k < respPause; k++) step();
            checkOutput("frozenOk", {31'd0, out_fetcher_ok}, 32'd1);
            ena = 1'b1;
        end
        step();
        checkOutput("respOk",     {31'd0, out_fetcher_ok}, 32'd0);
        checkOutput("respMemEna", {31'd0, out_mem_ena}, 32'd0);
        in_fetcher_ena = 1'b0;
    endtask

    // Rollback `delay` cycles after the request (0 = same cycle), with a
    // memory answer arriving together with it when a miss is outstanding.
    task automatic doRollback(input logic [31:0] addr, input int delay, input logic [31:0] data);
        bit hit;
        hit = modelHit(addr);
        in_fetcher_ena = 1'b1;
        in_fetcher_addr = addr;
        if (delay == 0) begin
            in_rollback = 1'b1;
            step();
            in_rollback = 1'b0;
            in_fetcher_ena = 1'b0;
            checkOutput("rbReqOk",     {31'd0, out_fetcher_ok}, 32'd0);
            checkOutput("rbReqMemEna", {31'd0, out_mem_ena}, 32'd0);
            return;
        end
        step();
        in_fetcher_ena = 1'b0;
        if (hit) begin
            checkOutput("rbHitOk", {31'd0, out_fetcher_ok}, 32'd1);
            in_rollback = 1'b1;
            step();
            in_rollback = 1'b0;
            checkOutput("rbRespOk", {31'd0, out_fetcher_ok}, 32'd0);
            return;
        end
        checkOutput("rbMissMemEna", {31'd0, out_mem_ena}, 32'd1);
        for (int k = 1; k < delay; k++) step();
        in_rollback = 1'b1;
        in_mem_ok = 1'b1;
        in_mem_data = data;
        step();
        in_rollback = 1'b0;
        in_mem_ok = 1'b0;
        checkOutput("rbMemEna", {31'd0, out_mem_ena}, 32'd0);
        checkOutput("rbOk",     {31'd0, out_fetcher_ok}, 32'd0);
        modelFill(addr, data);
        step();
        checkOutput("rbIdleOk", {31'd0, out_fetcher_ok}, 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        doReset();

        applyStimulus(32'h0000_0000, 4, 0, 32'h0000_0513, 0);
        applyStimulus(32'h0000_0002, 0, 0, 32'hDEAD_BEEF, 0);
        applyStimulus(32'h0000_0200, 2, 0, 32'hAAAA_5555, 0);
        applyStimulus(32'h0000_0000, 1, 0, 32'h0000_0513, 0);
        doRollback(32'h0000_0100, 2, 32'h1234_5678);
        applyStimulus(32'h0000_0100, 0, 0, 32'hDEAD_BEEF, 0);
        applyStimulus(32'h0000_0040, 2, 3, 32'hCAFE_F00D, 2);
        applyStimulus(32'hFFFC_0041, 0, 0, 32'hDEAD_BEEF, 0);
        applyStimulus(32'h0003_0000, 1, 0, 32'h0BAD_0001, 0);
        applyStimulus(32'h0003_0000, 0, 0, 32'h0BAD_0002, 0);
        doRollback(32'h0000_0100, 0, 32'h0);

        doReset();
        applyStimulus(32'h0000_0000, 0, 0, 32'h7777_0000, 0);

        for (int n = 0; n < 250; n++) begin
            addr = $urandom & 32'hFFFC_0000;
            if ($urandom_range(0, 9) == 0) begin
                addr[17:16] = 2'b11;
                addr[15:0]  = 16'($urandom);
            end else begin
                addr[15:9] = 7'($urandom_range(0, 3));
                addr[8:2]  = 7'($urandom_range(0, 7));
                addr[1:0]  = 2'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                doRollback(addr, $urandom_range(0, 3), $urandom);
            end else begin
                applyStimulus(addr, $urandom_range(0, 4),
                              ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                              $urandom,
                              ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
